// File: rtl/clock_pkg.sv
// Shared types and constants for the wall-clock timekeeper.
//   mode_t  : operating mode, RUN / SET_HOUR / SET_MIN (encoding 3 is illegal)
//   *_W     : bit widths of the seconds, minutes and hours fields
//   *_MAX   : highest value of the seconds and minutes fields
package clock_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } mode_t;

  localparam int SEC_W   = 6;
  localparam int MIN_W   = 6;
  localparam int HOUR_W  = 5;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;

endpackage

// File: rtl/timekeeper_ctrl_tick_gen.sv
// tick_gen: 1 Hz clock-enable prescaler. No derived clock; this only makes a pulse.
// Ports:
//   clk_in  in   system clock
//   rst     in   synchronous active-high reset
//   clr     in   restart the second: count returns to 0 and any pending tick is dropped
//   tick    out  registered one-cycle pulse, high in the cycle after count == TICKS_PER_SEC-1
//   half    out  1 while count < TICKS_PER_SEC/2 (first half of the second)
module tick_gen #(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic clk_in,
  input  logic rst,
  input  logic clr,
  output logic tick,
  output logic half
);

  localparam int CNT_W = $clog2(TICKS_PER_SEC);

  logic [CNT_W-1:0] cnt_q;
  logic             tick_q;

  always_ff @(posedge clk_in) begin
    if (rst || clr) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (cnt_q == CNT_W'(TICKS_PER_SEC - 1));
      if (cnt_q == CNT_W'(TICKS_PER_SEC - 1)) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign tick = tick_q;
  assign half = (cnt_q < CNT_W'(TICKS_PER_SEC / 2));

endmodule

// File: rtl/timekeeper_ctrl.sv
// timekeeper_ctrl: wall-clock time keeping and button-driven time setting for the
// seven-segment display. Everything runs on clk_in; the 1 Hz rate is a clock enable.
// Optional feature macro: TWELVE_HOUR_EN (hour shown as 1-12 plus a pm flag).
// Ports:
//   clk_in    in   system clock
//   rst       in   synchronous active-high reset
//   btn_mode  in   debounced one-cycle pulse, advances the mode
//   btn_inc   in   debounced one-cycle pulse, increments the field being set
//   tick_1hz  out  one-cycle pulse once per second
//   sec       out  seconds 0-59
//   min       out  minutes 0-59
//   hour      out  hours 0-23 (1-12 with TWELVE_HOUR_EN)
//   mode      out  0=RUN, 1=SET_HOUR, 2=SET_MIN
//   pm        out  afternoon flag (only with TWELVE_HOUR_EN)
//   blink     out  display-blank control for the field being set
//
// state    | meaning
// ---------+----------------------------------------------------------
// RUN      | time advances on each tick_1hz, btn_inc ignored
// SET_HOUR | ticks frozen, btn_inc bumps hour (wraps HOUR_MAX->0)
// SET_MIN  | ticks frozen, btn_inc bumps minute (wraps 59->0, no carry)
// 3        | illegal, returns to RUN on the next clock
module timekeeper_ctrl
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int HOUR_MAX      = 23
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              btn_mode,
  input  logic              btn_inc,
  output logic              tick_1hz,
  output logic [SEC_W-1:0]  sec,
  output logic [MIN_W-1:0]  min,
  output logic [HOUR_W-1:0] hour,
  output logic [1:0]        mode,
`ifdef TWELVE_HOUR_EN
  output logic              pm,
`endif
  output logic              blink
);

  mode_t             mode_q;
  logic [SEC_W-1:0]  sec_q;
  logic [MIN_W-1:0]  min_q;
  logic [HOUR_W-1:0] hour_q;
  logic              tick;
  logic              half;
  logic              clr_presc;

  // Leaving SET_MIN restarts the second so the first tick comes a full second later.
  assign clr_presc = (mode_q == SET_MIN) && btn_mode;

  tick_gen #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_tick_gen (
    .clk_in(clk_in),
    .rst   (rst),
    .clr   (clr_presc),
    .tick  (tick),
    .half  (half)
  );

  always_ff @(posedge clk_in) begin
    if (rst) begin
      mode_q <= RUN;
      sec_q  <= '0;
      min_q  <= '0;
      hour_q <= '0;
    end else begin
      case (mode_q)
        RUN: begin
          // A mode press wins over a coincident tick; sec is cleared anyway.
          if (btn_mode) begin
            mode_q <= SET_HOUR;
            sec_q  <= '0;
          end else if (tick) begin
            if (sec_q == SEC_W'(SEC_MAX)) begin
              sec_q <= '0;
              if (min_q == MIN_W'(MIN_MAX)) begin
                min_q <= '0;
                if (hour_q == HOUR_W'(HOUR_MAX)) begin
                  hour_q <= '0;
                end else begin
                  hour_q <= hour_q + HOUR_W'(1);
                end
              end else begin
                min_q <= min_q + MIN_W'(1);
              end
            end else begin
              sec_q <= sec_q + SEC_W'(1);
            end
          end
        end
        SET_HOUR: begin
          if (btn_mode) begin
            mode_q <= SET_MIN;
          end else if (btn_inc) begin
            if (hour_q == HOUR_W'(HOUR_MAX)) begin
              hour_q <= '0;
            end else begin
              hour_q <= hour_q + HOUR_W'(1);
            end
          end
        end
        SET_MIN: begin
          if (btn_mode) begin
            mode_q <= RUN;
            sec_q  <= '0;
          end else if (btn_inc) begin
            if (min_q == MIN_W'(MIN_MAX)) begin
              min_q <= '0;
            end else begin
              min_q <= min_q + MIN_W'(1);
            end
          end
        end
        default: mode_q <= RUN;
      endcase
    end
  end

  assign tick_1hz = tick;
  assign sec      = sec_q;
  assign min      = min_q;
  assign mode     = mode_q;
  // Blink follows the prescaler phase directly, so it is aligned to the second.
  assign blink    = (mode_q == RUN) ? 1'b1 : half;

`ifdef TWELVE_HOUR_EN
  // Internal time stays 0-23; only the presentation changes.
  always_comb begin
    if (hour_q == '0) begin
      hour = HOUR_W'(12);
    end else if (hour_q > HOUR_W'(12)) begin
      hour = hour_q - HOUR_W'(12);
    end else begin
      hour = hour_q;
    end
  end
  assign pm = (hour_q >= HOUR_W'(12));
`else
  assign hour = hour_q;
`endif

endmodule

// File: tb/tb_timekeeper_ctrl.sv
module tb_timekeeper_ctrl;

  localparam int TPS = 4;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       tick_1hz;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic [1:0] mode;
  logic       blink;
`ifdef TWELVE_HOUR_EN
  logic       pm;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model: time of day held as seconds since midnight.
  int m_p = 0;
  int m_tick = 0;
  int m_t = 0;
  int m_mode = 0;

  timekeeper_ctrl #(
    .TICKS_PER_SEC(TPS),
    .HOUR_MAX     (23)
  ) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .btn_mode(btn_mode),
    .btn_inc (btn_inc),
    .tick_1hz(tick_1hz),
    .sec     (sec),
    .min     (min),
    .hour    (hour),
    .mode    (mode),
`ifdef TWELVE_HOUR_EN
    .pm      (pm),
`endif
    .blink   (blink)
  );

  always #5 clk_in = ~clk_in;

  function automatic int disp_hour(input int h);
`ifdef TWELVE_HOUR_EN
    return (h % 12 == 0) ? 12 : h % 12;
`else
    return h;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_hour(input string name, input int internal_h);
    chk(name, int'(hour), disp_hour(internal_h));
`ifdef TWELVE_HOUR_EN
    chk({name, "_pm"}, int'(pm), (internal_h >= 12) ? 1 : 0);
`endif
  endtask

  task automatic model_step(input bit r, input bit bm, input bit bi);
    bit clr;
    int n_tick, n_p, h, mi, s;
    if (r) begin
      m_p = 0; m_tick = 0; m_t = 0; m_mode = 0;
      return;
    end
    clr    = (m_mode == 2) && bm;
    n_tick = (m_p == TPS - 1 && !clr) ? 1 : 0;
    n_p    = clr ? 0 : (m_p + 1) % TPS;
    h  = m_t / 3600;
    mi = (m_t / 60) % 60;
    s  = m_t % 60;
    case (m_mode)
      0: if (bm) begin m_mode = 1; m_t = m_t - s; end
         else if (m_tick != 0) m_t = (m_t + 1) % 86400;
      1: if (bm) m_mode = 2;
         else if (bi) m_t = ((h + 1) % 24) * 3600 + mi * 60 + s;
      default: if (bm) begin m_mode = 0; m_t = m_t - s; end
         else if (bi) m_t = h * 3600 + ((mi + 1) % 60) * 60 + s;
    endcase
    m_p = n_p;
    m_tick = n_tick;
  endtask

  task automatic compare_model();
    chk("m_tick", int'(tick_1hz), m_tick);
    chk("m_sec", int'(sec), m_t % 60);
    chk("m_min", int'(min), (m_t / 60) % 60);
    chk_hour("m_hour", m_t / 3600);
    chk("m_mode", int'(mode), m_mode);
    chk("m_blink", int'(blink), (m_mode == 0) ? 1 : ((m_p < TPS / 2) ? 1 : 0));
  endtask

  // Drive inputs for one edge, advance the model, then compare after the edge.
  task automatic cycle(input bit r, input bit bm, input bit bi);
    rst = r; btn_mode = bm; btn_inc = bi;
    model_step(r, bm, bi);
    @(posedge clk_in);
    #1;
    compare_model();
  endtask

  typedef struct {
    bit r, bm, bi;
    int tick, sec, min, hour, mode, blink;
  } vec_t;
  vec_t vq[$];

  task automatic add(input bit r, input bit bm, input bit bi, input int tk, input int s,
                     input int mi, input int h, input int md, input int bl);
    vec_t v;
    v = '{r, bm, bi, tk, s, mi, h, md, bl};
    vq.push_back(v);
  endtask

  initial begin
    // Hand-derived vectors from reset (TPS=4).
    add(1,0,0, 0,0,0,0,0,1);
    add(0,0,0, 0,0,0,0,0,1);
    add(0,0,0, 0,0,0,0,0,1);
    add(0,0,0, 0,0,0,0,0,1);
    add(0,0,0, 1,0,0,0,0,1);
    add(0,0,0, 0,1,0,0,0,1);
    add(0,0,0, 0,1,0,0,0,1);
    add(0,0,0, 0,1,0,0,0,1);
    add(0,0,0, 1,1,0,0,0,1);
    add(0,0,0, 0,2,0,0,0,1);
    add(0,0,0, 0,2,0,0,0,1);
    add(0,0,0, 0,2,0,0,0,1);
    add(0,0,0, 1,2,0,0,0,1);
    add(0,0,0, 0,3,0,0,0,1);
    add(0,1,0, 0,0,0,0,1,0);   // enter SET_HOUR, sec cleared
    add(0,0,1, 0,0,0,1,1,0);
    add(0,0,1, 1,0,0,2,1,1);
    add(0,0,1, 0,0,0,3,1,1);   // tick ignored in SET_HOUR
    add(0,0,0, 0,0,0,3,1,0);
    add(0,0,0, 0,0,0,3,1,0);
    add(0,0,0, 1,0,0,3,1,1);
    add(0,0,0, 0,0,0,3,1,1);
    add(0,1,1, 0,0,0,3,2,0);   // mode wins, inc dropped
    add(0,0,1, 0,0,1,3,2,0);
    add(0,1,0, 0,0,1,3,0,1);   // back to RUN, pending tick dropped
    add(0,0,0, 0,0,1,3,0,1);
    add(0,0,0, 0,0,1,3,0,1);
    add(0,0,0, 0,0,1,3,0,1);
    add(0,0,0, 1,0,1,3,0,1);   // tick exactly 4 cycles after leaving SET_MIN
    add(0,0,0, 0,1,1,3,0,1);
    add(0,0,1, 0,1,1,3,0,1);   // inc ignored in RUN
    add(1,0,0, 0,0,0,0,0,1);   // reset
    foreach (vq[i]) begin
      cycle(vq[i].r, vq[i].bm, vq[i].bi);
      chk($sformatf("v%0d_tick", i), int'(tick_1hz), vq[i].tick);
      chk($sformatf("v%0d_sec", i), int'(sec), vq[i].sec);
      chk($sformatf("v%0d_min", i), int'(min), vq[i].min);
      chk_hour($sformatf("v%0d_hour", i), vq[i].hour);
      chk($sformatf("v%0d_mode", i), int'(mode), vq[i].mode);
      chk($sformatf("v%0d_blink", i), int'(blink), vq[i].blink);
    end

    // Preload 23:59 via the set path, then run through midnight.
    cycle(0,1,0);
    for (int i = 1; i <= 24; i++) begin
      cycle(0,0,1);
`ifdef TWELVE_HOUR_EN
      if (i == 13) begin
        chk("h12_13_hour", int'(hour), 1);
        chk("h12_13_pm", int'(pm), 1);
      end
      if (i == 24) begin
        chk("h12_0_hour", int'(hour), 12);
        chk("h12_0_pm", int'(pm), 0);
      end
`endif
      if (i == 23) chk_hour("set_hour23", 23);
      if (i == 24) chk_hour("hour_wrap", 0);
    end
    for (int i = 0; i < 23; i++) cycle(0,0,1);
    cycle(0,1,0);
    for (int i = 0; i < 59; i++) cycle(0,0,1);
    chk("set_min59", int'(min), 59);
    cycle(0,0,1);
    chk("min_wrap", int'(min), 0);
    chk_hour("min_wrap_no_carry", 23);
    for (int i = 0; i < 59; i++) cycle(0,0,1);
    cycle(0,1,0);
    chk("run_mode", int'(mode), 0);
    for (int i = 1; i <= 4; i++) begin
      cycle(0,0,0);
      chk($sformatf("first_tick_c%0d", i), int'(tick_1hz), (i == 4) ? 1 : 0);
    end
    for (int i = 0; i < 229; i++) cycle(0,0,0);
    chk("pre_sec58", int'(sec), 58);
    chk("pre_min59", int'(min), 59);
    chk_hour("pre_hour23", 23);
    for (int i = 0; i < 4; i++) cycle(0,0,0);
    chk("t235959_sec", int'(sec), 59);
    for (int i = 0; i < 4; i++) cycle(0,0,0);
    chk("midnight_sec", int'(sec), 0);
    chk("midnight_min", int'(min), 0);
    chk_hour("midnight_hour", 0);

    // Reset while in SET_MIN with hour=7.
    cycle(0,1,0);
    for (int i = 0; i < 7; i++) cycle(0,0,1);
    cycle(0,1,0);
    chk("pre_rst_mode", int'(mode), 2);
    chk_hour("pre_rst_hour", 7);
    cycle(1,0,0);
    chk("rst_mode", int'(mode), 0);
    chk_hour("rst_hour", 0);
    chk("rst_sec", int'(sec), 0);
    chk("rst_min", int'(min), 0);
    chk("rst_tick", int'(tick_1hz), 0);
    chk("rst_blink", int'(blink), 1);

    // Randomized stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 299) == 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/timekeeper_ctrl.md
Name: timekeeper_ctrl

Overview:
- Sequences the wall-clock time for the digital clock display.
- Owns a clock-enable prescaler that produces a 1 Hz tick. No derived clock is generated; everything runs on clk_in.
- Runs the second/minute/hour counters and a button-driven set-time state machine.
- Its outputs drive the seven-segment display decoders directly.

Parameters:
- TICKS_PER_SEC, 50000000: clk_in cycles per second. Must be >= 4; the bench uses 4.
- HOUR_MAX, 23: highest hour value in 24-hour mode.

Ports:
- clk_in  input  1  system clock, 50 MHz.
- rst  input  1  synchronous, active-high reset.
- btn_mode  input  1  single-cycle pulse, already debounced; advances the mode.
- btn_inc  input  1  single-cycle pulse, already debounced; increments the selected field.
- tick_1hz  output  1  one-cycle pulse, once per second.
- sec  output  6  seconds, 0-59.
- min  output  6  minutes, 0-59.
- hour  output  5  hours, 0-23.
- mode  output  2  0=RUN, 1=SET_HOUR, 2=SET_MIN.
- blink  output  1  display-blank control for the field being set.

Behaviour:
- Clock and reset: one clock, clk_in. Reset rst is synchronous and active-high.
- Reset values: prescaler=0, tick_1hz=0, sec=0, min=0, hour=0, mode=RUN, blink=1.
- Prescaler:
  - Counter width is $clog2(TICKS_PER_SEC).
  - Counts 0..TICKS_PER_SEC-1, then wraps to 0.
  - tick_1hz is registered. It is high for exactly the one cycle after the counter holds TICKS_PER_SEC-1.
  - The prescaler runs in every mode.
- RUN state:
  - Time advances on the cycle tick_1hz is high, so counters update 1 cycle after tick_1hz asserts.
  - sec 59->0 carries into min.
  - min 59->0 carries into hour.
  - hour HOUR_MAX->0.
  - A full carry (23:59:59 -> 00:00:00) completes in a single cycle.
- FSM transitions:
  - RUN -> SET_HOUR on btn_mode.
  - SET_HOUR -> SET_MIN on btn_mode.
  - SET_MIN -> RUN on btn_mode.
  - Encoding 3 is illegal and recovers to RUN on the next clock.
- Entering SET_HOUR: sec is cleared to 0.
- In SET states:
  - Ticks do not advance time.
  - btn_inc in SET_HOUR: hour+1, wrapping HOUR_MAX->0.
  - btn_inc in SET_MIN: min+1, wrapping 59->0, with no carry into hour.
- Leaving SET_MIN to RUN: prescaler and sec are cleared to 0, so the first post-set tick arrives a full TICKS_PER_SEC later.
- btn_inc in RUN: ignored.
- btn_mode and btn_inc in the same cycle: the mode change wins; btn_inc is dropped.
- blink:
  - Held at 1 in RUN.
  - In SET states, 1 while prescaler < TICKS_PER_SEC/2, otherwise 0.
- Reset mid-operation: returns to the reset values on the next edge, regardless of mode.

Optional Feature:
- Macro: TWELVE_HOUR_EN.
- Defined:
  - hour is presented as 1-12.
  - An extra output pm (1 bit, reset 0) is added.
  - Internal time remains 0-23; conversion is combinational from the internal hour.
  - Internal 0 -> 12 AM, 12 -> 12 PM, 13 -> 1 PM.
  - SET_HOUR increments the internal hour, so the AM/PM state wraps with it.
- Undefined: no pm port; hour is 0-23.

Decomposition:
- Package clock_pkg holds:
  - mode_t enum {RUN, SET_HOUR, SET_MIN}.
  - Constants SEC_MAX=59 and MIN_MAX=59.
  - Field widths SEC_W=6, MIN_W=6, HOUR_W=5.
- Sub-module tick_gen:
  - Parameter TICKS_PER_SEC.
  - Inputs clk_in, rst, clr.
  - Outputs tick and half (1 while count < TICKS_PER_SEC/2).
- The top level holds the FSM and the time counters.

Test Plan (TICKS_PER_SEC=4):
- Reset, then run 12 cycles -> tick_1hz pulses every 4 cycles; sec=3 after the third tick; mode=0; blink=1.
- Preload 23:59:58 via the set path, return to RUN, wait for 2 ticks -> 23:59:59, then 00:00:00 in one cycle.
- btn_mode, then 3x btn_inc -> mode=1, sec=0, hour=3. Ticks during SET_HOUR leave sec=0.
- In SET_MIN with min=59, btn_inc -> min=0 and hour unchanged. Then btn_mode -> mode=0, prescaler=0, and the next tick arrives exactly 4 cycles later.
- btn_mode and btn_inc together in SET_HOUR (hour=5) -> mode=2, hour=5. In SET_MIN, blink is 1 for 2 cycles and 0 for 2 cycles.
- Assert rst while in SET_MIN with hour=7 -> next cycle all reset values. With TWELVE_HOUR_EN, internal 13 -> hour=1, pm=1; internal 0 -> hour=12, pm=0.
